middle_page_summer: RTL and testbench

// - Downstream of the line sorter: once the sorter has reordered every update line in the shared page memory, this block scans each line, reads its middle page number and accumulates two sums.
// - sum_all: middle pages of every line. sum_fixed: middle pages of lines the sorter had to reorder, which is the part-2 answer.
// - Read-only master on the page memory (row-major, ROW_STRIDE bytes per row). Started by the sorter's done pulse.

---
 rtl/aoc_d5_pkg.sv | 11 +
 rtl/middle_page_summer.sv | 149 ++++++++++++++
 tb/tb_middle_page_summer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/aoc_d5_pkg.sv
// Constants and types shared by the line sorter and the middle-page summer.
package aoc_d5_pkg;

    localparam int unsigned ROW_STRIDE = 32;
    localparam int unsigned MAX_LINES  = 512;

    typedef logic [7:0] page_t;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACCUM, DONE} msum_state_t;

endpackage

// File: rtl/middle_page_summer.sv
// Scans every sorted line in page memory, reads its middle page and accumulates
// the total over all lines and over the lines the sorter had to reorder.
module middle_page_summer
    import aoc_d5_pkg::*;
#(
    parameter int unsigned SUM_W = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          go,
    input  logic [16:0]                   num_lines,
    input  logic [MAX_LINES-1:0][7:0]     lengths,
    input  logic [MAX_LINES-1:0]          reordered,
    output logic [31:0]                   mem_addr,
    output logic                          mem_re,
    input  logic [31:0]                   mem_rdata,
    output logic                          busy,
    output logic                          done,
    output logic [SUM_W-1:0]              sum_all,
    output logic [SUM_W-1:0]              sum_fixed,
    output logic                          len_err
);

    localparam int unsigned RowW = $clog2(MAX_LINES + 1);
    localparam int unsigned IdxW = $clog2(MAX_LINES);

    msum_state_t      state_q, state_d;
    logic [RowW-1:0]  row_q, row_d;
    logic [RowW-1:0]  num_q, num_d;
    logic [31:0]      addr_q, addr_d;
    logic             re_q, re_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [SUM_W-1:0] sum_all_q, sum_all_d;
    logic [SUM_W-1:0] sum_fixed_q, sum_fixed_d;
    logic             err_q, err_d;

    logic [IdxW-1:0]  idx;
    logic [7:0]       cur_len;
    page_t            page;
    logic             unused_rdata;

    function automatic logic [31:0] mid_addr(input logic [RowW-1:0] row, input logic [7:0] len);
        return 32'(row) * 32'(ROW_STRIDE) + 32'(len >> 1);
    endfunction

    // row_q reaches MAX_LINES only when the scan is finishing; keep the index in range anyway.
    assign idx          = (row_q < RowW'(MAX_LINES)) ? row_q[IdxW-1:0] : '0;
    assign cur_len      = lengths[idx];
    assign page         = mem_rdata[7:0];
    assign unused_rdata = ^mem_rdata[31:8];

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        num_d       = num_q;
        addr_d      = addr_q;
        re_d        = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        sum_all_d   = sum_all_q;
        sum_fixed_d = sum_fixed_q;
        err_d       = err_q;

        unique case (state_q)
            IDLE: begin
                if (go) begin
                    num_d       = (num_lines > 17'(MAX_LINES)) ? RowW'(MAX_LINES)
                                                               : num_lines[RowW-1:0];
                    row_d       = '0;
                    sum_all_d   = '0;
                    sum_fixed_d = '0;
                    err_d       = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (row_q == num_q) begin
                    // done is high for exactly the cycle spent in DONE, so a go then is ignored
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else if (cur_len == 8'd0) begin
                    row_d = row_q + RowW'(1);
                end else if (32'(cur_len) > ROW_STRIDE) begin
                    err_d = 1'b1;
                    row_d = row_q + RowW'(1);
                end else begin
                    addr_d  = mid_addr(row_q, cur_len);
                    re_d    = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                state_d = ACCUM;
            end
            ACCUM: begin
                sum_all_d = sum_all_q + SUM_W'(page);
                if (reordered[idx]) begin
                    sum_fixed_d = sum_fixed_q + SUM_W'(page);
                end
                row_d   = row_q + RowW'(1);
                state_d = ISSUE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            row_q       <= '0;
            num_q       <= '0;
            addr_q      <= '0;
            re_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sum_all_q   <= '0;
            sum_fixed_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            num_q       <= num_d;
            addr_q      <= addr_d;
            re_q        <= re_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sum_all_q   <= sum_all_d;
            sum_fixed_q <= sum_fixed_d;
            err_q       <= err_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_re    = re_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign sum_all   = sum_all_q;
    assign sum_fixed = sum_fixed_q;
    assign len_err   = err_q;

endmodule

// File: tb/tb_middle_page_summer.sv
// Self-checking bench for middle_page_summer: table vectors, corner sequences and
// randomized scans compared against a row-by-row reference model.
module tb_middle_page_summer;
    import aoc_d5_pkg::*;

    localparam int MemWords = 16384;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      go = 1'b0;
    logic [16:0]               num_lines = '0;
    logic [MAX_LINES-1:0][7:0] lengths = '0;
    logic [MAX_LINES-1:0]      reordered = '0;
    logic [31:0]               mem_addr;
    logic                      mem_re;
    logic [31:0]               mem_rdata = '0;
    logic                      busy;
    logic                      done;
    logic [15:0]               sum_all;
    logic [15:0]               sum_fixed;
    logic                      len_err;

    middle_page_summer #(.SUM_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .num_lines (num_lines),
        .lengths   (lengths),
        .reordered (reordered),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .sum_all   (sum_all),
        .sum_fixed (sum_fixed),
        .len_err   (len_err)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [MemWords];

    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr[13:0]];
    end

    int n_total = 0;
    int n_bad   = 0;
    int done_cnt = 0;
    int re_viol  = 0;
    logic prev_re = 1'b0;
    int reads[$];
    int exp_addr[$];

    // Observe just after each edge, once the DUT registers have settled.
    always @(posedge clk) begin
        #1;
        if (prev_re && mem_re) re_viol++;
        prev_re = mem_re;
        if (mem_re) reads.push_back(int'(mem_addr));
        if (done) done_cnt++;
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0d want=%0d", nm, got, want);
        end
    endtask

    // Reference: walk the rows by the rules, plain integer arithmetic.
    task automatic model(input int nl, output int ea, output int ef, output bit ee,
                         output int el);
        int n;
        n  = (nl > int'(MAX_LINES)) ? int'(MAX_LINES) : nl;
        ea = 0; ef = 0; ee = 0; el = 2;
        exp_addr.delete();
        for (int r = 0; r < n; r++) begin
            int len;
            len = int'(lengths[r]);
            if (len == 0) begin
                el += 1;
            end else if (len > 32) begin
                ee = 1;
                el += 1;
            end else begin
                int a;
                int v;
                a = r * 32 + len / 2;
                v = int'(mem[a] & 32'hff);
                exp_addr.push_back(a);
                ea = (ea + v) % 65536;
                if (reordered[r]) ef = (ef + v) % 65536;
                el += 3;
            end
        end
    endtask

    task automatic run_scan(input string tag, input logic [16:0] nl, input int e_all,
                            input int e_fix, input bit e_err, input int e_lat);
        int cyc;
        reads.delete();
        done_cnt = 0;
        re_viol  = 0;
        num_lines = nl;
        go  = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            go = (cyc == 1);  // stray go while busy must be ignored
        end while (!done && cyc < 5000);
        chk({tag, " done_seen"}, done, 1);
        chk({tag, " latency"}, cyc, e_lat);
        chk({tag, " busy_at_done"}, busy, 0);
        chk({tag, " sum_all"}, sum_all, e_all);
        chk({tag, " sum_fixed"}, sum_fixed, e_fix);
        chk({tag, " len_err"}, len_err, e_err);
        go = 1'b1;  // go during the done cycle must be ignored too
        @(negedge clk);
        go = 1'b0;
        chk({tag, " go_on_done_busy"}, busy, 0);
        @(negedge clk);
        chk({tag, " done_pulse_width"}, done_cnt, 1);
        chk({tag, " one_outstanding"}, re_viol, 0);
        chk({tag, " sums_hold"}, sum_all, e_all);
        chk({tag, " read_count"}, reads.size(), exp_addr.size());
        for (int i = 0; i < reads.size() && i < exp_addr.size(); i++)
            chk({tag, " read_addr"}, reads[i], exp_addr[i]);
    endtask

    typedef struct packed {
        logic [16:0]     nrows;
        logic [3:0][7:0] len;
        logic [3:0][7:0] mid;
        logic [3:0]      reo;
        logic [15:0]     e_all;
        logic [15:0]     e_fix;
        logic            e_err;
        logic [15:0]     e_lat;
    } vec_t;

    vec_t vecs [4];

    task automatic fill_mem_pattern();
        for (int a = 0; a < MemWords; a++) mem[a] = 32'h5A5A_0000 | 32'(a);
    endtask

    // Rows past nrows get a valid length and a large middle so an overrun shows up in the sums.
    task automatic setup_vec(input vec_t v);
        fill_mem_pattern();
        for (int r = 0; r < int'(MAX_LINES); r++) begin
            if (r < 4 && r < int'(v.nrows)) begin
                lengths[r]   = v.len[r];
                reordered[r] = v.reo[r];
                if (v.len[r] != 0 && v.len[r] <= 8'd32)
                    mem[r * 32 + int'(v.len[r]) / 2] = 32'hFFFF_FF00 | 32'(v.mid[r]);
            end else begin
                lengths[r]   = 8'd5;
                reordered[r] = 1'b1;
                mem[r * 32 + 2] = 32'h0000_00C8;
            end
        end
    endtask

    initial begin
        int ea, ef, el;
        bit ee;
        int nre;

        vecs[0] = '{nrows: 17'd3, len: {8'd0, 8'd5, 8'd3, 8'd5}, mid: {8'd0, 8'd53, 8'd29, 8'd47},
                    reo: 4'b0010, e_all: 16'd129, e_fix: 16'd29, e_err: 1'b0, e_lat: 16'd11};
        vecs[1] = '{nrows: 17'd0, len: '0, mid: '0, reo: 4'b0000,
                    e_all: 16'd0, e_fix: 16'd0, e_err: 1'b0, e_lat: 16'd2};
        vecs[2] = '{nrows: 17'd3, len: {8'd0, 8'd1, 8'd40, 8'd3}, mid: {8'd0, 8'd22, 8'd0, 8'd11},
                    reo: 4'b0111, e_all: 16'd33, e_fix: 16'd33, e_err: 1'b1, e_lat: 16'd9};
        vecs[3] = '{nrows: 17'd3, len: {8'd0, 8'd2, 8'd0, 8'd4}, mid: {8'd0, 8'd9, 8'd0, 8'd30},
                    reo: 4'b0111, e_all: 16'd39, e_fix: 16'd39, e_err: 1'b0, e_lat: 16'd9};

        fill_mem_pattern();
        repeat (3) @(negedge clk);
        chk("reset mem_addr", mem_addr, 0);
        chk("reset mem_re", mem_re, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset sum_all", sum_all, 0);
        chk("reset sum_fixed", sum_fixed, 0);
        chk("reset len_err", len_err, 0);
        rst = 1'b0;
        @(negedge clk);

        // vecs[3] follows the len_err case, so it also checks that go clears len_err.
        for (int i = 0; i < 4; i++) begin
            setup_vec(vecs[i]);
            model(int'(vecs[i].nrows), ea, ef, ee, el);
            run_scan($sformatf("vec%0d", i), vecs[i].nrows, int'(vecs[i].e_all),
                     int'(vecs[i].e_fix), vecs[i].e_err, int'(vecs[i].e_lat));
        end

        // 300 rows of middle 255: wraps the 16-bit accumulators.
        fill_mem_pattern();
        for (int r = 0; r < int'(MAX_LINES); r++) begin
            lengths[r]   = 8'($urandom_range(1, 32));
            reordered[r] = 1'b1;
            mem[r * 32 + int'(lengths[r]) / 2] = 32'h1234_56FF;
        end
        model(300, ea, ef, ee, el);
        run_scan("wrap300", 17'd300, 10964, 10964, 1'b0, 902);

        // Abort with reset while waiting on row 1's read, then rerun cleanly.
        setup_vec(vecs[0]);
        model(3, ea, ef, ee, el);
        done_cnt  = 0;
        num_lines = 17'd3;
        go  = 1'b1;
        nre = 0;
        for (int c = 0; c < 50 && nre < 2; c++) begin
            @(negedge clk);
            go = 1'b0;
            if (mem_re) nre++;
        end
        chk("abort reached_row1_read", nre, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort sum_all", sum_all, 0);
        chk("abort sum_fixed", sum_fixed, 0);
        chk("abort mem_re", mem_re, 0);
        repeat (3) @(negedge clk);
        chk("abort no_done", done_cnt, 0);
        chk("abort idle", busy, 0);
        run_scan("rerun", 17'd3, 129, 29, 1'b0, 11);

        // Randomized scans; the last one requests more rows than fit and must clamp.
        for (int it = 0; it < 6; it++) begin
            logic [16:0] nl;
            for (int a = 0; a < MemWords; a++) mem[a] = $urandom;
            for (int r = 0; r < int'(MAX_LINES); r++) begin
                int k;
                k = $urandom_range(0, 9);
                if (k == 0)      lengths[r] = 8'd0;
                else if (k == 1) lengths[r] = 8'($urandom_range(33, 255));
                else             lengths[r] = 8'($urandom_range(1, 32));
                reordered[r] = 1'($urandom_range(0, 1));
            end
            nl = (it == 5) ? 17'd100000 : 17'($urandom_range(1, 24));
            model(int'(nl), ea, ef, ee, el);
            run_scan($sformatf("rand%0d", it), nl, ea, ef, ee, el);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
